// File: rtl/regfile_8x16_if.sv
// Register file access bus: one write port, two read ports, debug write count.
//   master : drives we/waddr/wdata/raddr_a/raddr_b, receives rdata_a/rdata_b/wr_count
//   slave  : the register file side
interface regfile_8x16_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [DEPTH_LOG2-1:0] raddr_a;
  logic [WIDTH-1:0]      rdata_a;
  logic [DEPTH_LOG2-1:0] raddr_b;
  logic [WIDTH-1:0]      rdata_b;
  logic [7:0]            wr_count;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_count
  );
endinterface

// File: rtl/regfile_8x16.sv
// Eight-entry general-purpose register bank for the emulator datapath.
//   clk   : rising-edge clock for all state
//   rst_n : async active-low reset, clears registers and wr_count
//   bus   : regfile_8x16_if.slave (write port, read ports A/B, wr_count)
// Reads are combinational; optional write-to-read bypass and hardwired-zero r0.

// One combinational read port.
module regfile_8x16_rd #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter bit ZERO_REG0  = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                                rst_n,
  input  logic [DEPTH_LOG2-1:0]               raddr,
  input  logic [2**DEPTH_LOG2-1:0][WIDTH-1:0] mem,
  input  logic                                commit,
  input  logic [DEPTH_LOG2-1:0]               waddr,
  input  logic [WIDTH-1:0]                    wdata,
  output logic [WIDTH-1:0]                    rdata
);
  always_comb begin
    rdata = '0;
    if (rst_n) begin
      // commit already excludes discarded r0 writes, so r0 never bypasses
      if (BYPASS && commit && (raddr == waddr)) rdata = wdata;
      else                                      rdata = mem[raddr];
      if (ZERO_REG0 && (raddr == '0))           rdata = '0;
    end
  end
endmodule

module regfile_8x16 #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter bit ZERO_REG0  = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  regfile_8x16_if.slave bus
);
  localparam int NREG   = 2**DEPTH_LOG2;
  localparam int NPORTS = 2;

  logic [NREG-1:0][WIDTH-1:0]         mem;
  logic [7:0]                         cnt;
  logic                               commit;
  logic [NPORTS-1:0][DEPTH_LOG2-1:0]  raddr;
  logic [NPORTS-1:0][WIDTH-1:0]       rdata;

  // X on we makes commit X; the if() below then takes the no-write branch,
  // so no register is touched.
  assign commit = bus.we && !(ZERO_REG0 && (bus.waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      cnt <= '0;
    end else if (commit) begin
      mem[bus.waddr] <= bus.wdata;
      if (cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
  end

  assign raddr = {bus.raddr_b, bus.raddr_a};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    regfile_8x16_rd #(
      .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2),
      .ZERO_REG0(ZERO_REG0), .BYPASS(BYPASS)
    ) u_rd (
      .rst_n  (rst_n),
      .raddr  (raddr[p]),
      .mem    (mem),
      .commit (commit),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .rdata  (rdata[p])
    );
  end

  assign bus.rdata_a  = rdata[0];
  assign bus.rdata_b  = rdata[1];
  assign bus.wr_count = cnt;
endmodule

// File: tb/tb_regfile_8x16.sv
// Bench for regfile_8x16: two instances share stimulus, one with
// ZERO_REG0=1/BYPASS=1 (index 0) and one with ZERO_REG0=0/BYPASS=0 (index 1).
module tb_regfile_8x16;
  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  ra = '0;
  logic [2:0]  rb = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] a0, b0, a1, b1;
    logic [7:0]  c0, c1;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic [15:0] mm [2][8];
  logic [7:0]  mc [2];

  regfile_8x16_if #(.WIDTH(16), .DEPTH_LOG2(3)) if_z ();
  regfile_8x16_if #(.WIDTH(16), .DEPTH_LOG2(3)) if_p ();

  assign if_z.we = we;  assign if_z.waddr = waddr; assign if_z.wdata = wdata;
  assign if_z.raddr_a = ra; assign if_z.raddr_b = rb;
  assign if_p.we = we;  assign if_p.waddr = waddr; assign if_p.wdata = wdata;
  assign if_p.raddr_a = ra; assign if_p.raddr_b = rb;

  regfile_8x16 #(.ZERO_REG0(1'b1), .BYPASS(1'b1)) dut_z (.clk(clk), .rst_n(rst_n), .bus(if_z));
  regfile_8x16 #(.ZERO_REG0(1'b0), .BYPASS(1'b0)) dut_p (.clk(clk), .rst_n(rst_n), .bus(if_p));

  // Gateable clock so the no-edge test can hold clk low.
  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference model of both configurations.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 8; r++) mm[k][r] <= '0;
        mc[k] <= '0;
      end
    end else if (we === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (!(k == 0 && waddr == 3'd0)) begin
          mm[k][waddr] <= wdata;
          if (mc[k] != 8'hFF) mc[k] <= mc[k] + 8'd1;
        end
      end
    end
  end

  function automatic logic [15:0] rd(int k, logic [2:0] a);
    bit z = (k == 0);
    bit bp = (k == 0);
    if (!rst_n) return 16'h0;
    if (z && a == 3'd0) return 16'h0;
    if (bp && we === 1'b1 && !(z && waddr == 3'd0) && a == waddr) return wdata;
    return mm[k][a];
  endfunction

  function automatic exp_t mk(string tag);
    exp_t x;
    x.tag = tag;
    x.a0 = rd(0, ra); x.b0 = rd(0, rb);
    x.a1 = rd(1, ra); x.b1 = rd(1, rb);
    x.c0 = rst_n ? mc[0] : 8'h0;
    x.c1 = rst_n ? mc[1] : 8'h0;
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    q.push_back(mk("rst_init"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
        {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1}) begin
      bad++;
      $display("FAIL %s got %h %h %h %h %h %h want %h %h %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count,
        e.a0, e.b0, e.a1, e.b1, e.c0, e.c1);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      we = 1'b1; waddr = r[2:0]; wdata = 16'hFFFF;
      @(negedge clk);
    end
    we = 1'b0; ra = 3'd7; rb = 3'd0;
    #1;
    q.push_back(mk("rst_fill"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
        {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1}) begin
      bad++;
      $display("FAIL %s got %h %h %h %h %h %h want %h %h %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count,
        e.a0, e.b0, e.a1, e.b1, e.c0, e.c1);
    end
    // mid-cycle reset pulse: clk is low here, no edge until well after
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      ra = i[2:0]; rb = 3'(i + 4);
      #0;
      q.push_back(mk("rst_async"));
    end
    for (int i = 0; i < 4; i++) begin
      ra = i[2:0]; rb = 3'(i + 4);
      #0.1;
      e = q.pop_front(); total++;
      if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
          {16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0} ||
          {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1} !== 80'h0) begin
        bad++;
        $display("FAIL %s[%0d] got %h %h %h %h %h %h want 0", e.tag, i,
          if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    we = 1'b1; waddr = 3'd3; wdata = 16'b1010110010101100; ra = 3'd3; rb = 3'd5;
    #1;
    q.push_back(mk("wr_pre_edge"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_p.rdata_a} !== {e.a0, e.a1} || e.a1 !== 16'h0) begin
      bad++;
      $display("FAIL %s got z=%h p=%h want z=%h p=%h", e.tag, if_z.rdata_a, if_p.rdata_a, e.a0, e.a1);
    end
    @(negedge clk);
    waddr = 3'd5; wdata = 16'h1234;
    @(negedge clk);
    we = 1'b0;
    #1;
    q.push_back(mk("wr_readback"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b} !== {e.a0, e.b0, e.a1, e.b1} ||
        {e.a0, e.b0} !== {16'b1010110010101100, 16'h1234}) begin
      bad++;
      $display("FAIL %s got %h %h %h %h want %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, e.a0, e.b0, e.a1, e.b1);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; ra = 3'd2; rb = 3'd2;
    #1;
    q.push_back(mk("byp_pre_edge"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b} !== {e.a0, e.b0, e.a1, e.b1} ||
        e.a0 !== 16'hBEEF) begin
      bad++;
      $display("FAIL %s got %h %h %h %h want %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, e.a0, e.b0, e.a1, e.b1);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    q.push_back(mk("byp_post_edge"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b} !== {e.a0, e.b0, e.a1, e.b1} ||
        e.a1 !== 16'hBEEF) begin
      bad++;
      $display("FAIL %s got %h %h %h %h want %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, e.a0, e.b0, e.a1, e.b1);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we = 1'b1; waddr = 3'd0; wdata = 16'h5555; ra = 3'd0; rb = 3'd0;
    #1;
    q.push_back(mk("zero_pre_edge"));
    @(negedge clk);
    we = 1'b0;
    #1;
    q.push_back(mk("zero_post_edge"));
    for (int i = 0; i < 2; i++) begin
      e = q.pop_front(); total++;
      if (i == 0 ? ({if_z.rdata_a, if_z.rdata_b} !== {e.a0, e.b0})
                 : ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
                    {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1} || e.a1 !== 16'h5555)) begin
        bad++;
        $display("FAIL %s got %h %h %h %h %h %h want %h %h %h %h %h %h", e.tag,
          if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count,
          e.a0, e.b0, e.a1, e.b1, e.c0, e.c1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] prev = 3'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 3'($urandom_range(0, 7)); wdata = 16'($urandom);
      ra = waddr; rb = prev;
      #1;
      q.push_back(mk("b2b"));
      e = q.pop_front(); total++;
      if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
          {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1}) begin
        bad++;
        $display("FAIL %s[%0d] got %h %h %h %h %h %h want %h %h %h %h %h %h", e.tag, i,
          if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count,
          e.a0, e.b0, e.a1, e.b1, e.c0, e.c1);
      end
      prev = waddr;
    end
    @(negedge clk); we = 1'b0;
  endtask

  task automatic test_no_edge();
    @(negedge clk);
    clk_en = 1'b0;
    ra = 3'd4; rb = 3'd6;
    #1;
    q.push_back(mk("noedge"));
    we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waddr = 3'(i + 3); wdata = 16'($urandom);
      #2;
    end
    we = 1'b0;
    #1;
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
        {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1}) begin
      bad++;
      $display("FAIL %s got %h %h %h %h %h %h want %h %h %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count,
        e.a0, e.b0, e.a1, e.b1, e.c0, e.c1);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 3'((i % 7) + 1); wdata = 16'(i);
    end
    @(negedge clk);
    we = 1'b0; ra = 3'd7; rb = 3'd1;
    #1;
    q.push_back(mk("sat"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !==
        {e.a0, e.b0, e.a1, e.b1, e.c0, e.c1} || e.c0 !== 8'hFF) begin
      bad++;
      $display("FAIL %s got %h %h %h %h %h %h want %h %h %h %h %h %h", e.tag,
        if_z.rdata_a, if_z.rdata_b, if_p.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count,
        e.a0, e.b0, e.a1, e.b1, e.c0, e.c1);
    end
    #1 rst_n = 1'b0;
    #1;
    q.push_back(mk("sat_reset"));
    e = q.pop_front(); total++;
    if ({if_z.wr_count, if_p.wr_count, if_z.rdata_a, if_p.rdata_b} !== {e.c0, e.c1, e.a0, e.b1} ||
        {e.c0, e.c1} !== 16'h0) begin
      bad++;
      $display("FAIL %s got %h %h %h %h want %h %h %h %h", e.tag,
        if_z.wr_count, if_p.wr_count, if_z.rdata_a, if_p.rdata_b, e.c0, e.c1, e.a0, e.b1);
    end
    @(negedge clk); rst_n = 1'b1;
    // write presented on the deassertion edge commits
    we = 1'b1; waddr = 3'd6; wdata = 16'hA5A5; ra = 3'd6; rb = 3'd6;
    @(negedge clk);
    we = 1'b0;
    #1;
    q.push_back(mk("post_reset_wr"));
    e = q.pop_front(); total++;
    if ({if_z.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count} !== {e.a0, e.b1, e.c0, e.c1} ||
        e.c0 !== 8'd1) begin
      bad++;
      $display("FAIL %s got %h %h %h %h want %h %h %h %h", e.tag,
        if_z.rdata_a, if_p.rdata_b, if_z.wr_count, if_p.wr_count, e.a0, e.b1, e.c0, e.c1);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_no_edge();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
